// File: rtl/chip8_draw_engine.sv
// CHIP-8 sprite draw (DXYN) and screen clear (00E0) engine over a DISP_W x DISP_H
// bit framebuffer, fetching sprite rows through a 1-cycle-latency read port.
module chip8_draw_engine #(
    parameter int DISP_W = 64,
    parameter int DISP_H = 32,
    parameter int ADDR_W = 12,
    parameter int CLIP   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     clear,
    input  logic [7:0]               x_in,
    input  logic [7:0]               y_in,
    input  logic [3:0]               n_in,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_read,
    input  logic [7:0]               mem_data_in,
    output logic                     busy,
    output logic                     done,
    output logic                     collision,
    output logic [DISP_W*DISP_H-1:0] display
);

    localparam int XW = $clog2(DISP_W);
    localparam int YW = (DISP_H > 1) ? $clog2(DISP_H) : 1;
    localparam logic [YW+4:0] H_LIM    = (YW+5)'(DISP_H);
    localparam logic [YW-1:0] LAST_ROW = YW'(DISP_H - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, CLR, FIN} state_t;

    // Request semantics: start/clear are single-cycle strobes sampled only in IDLE;
    // a strobe seen in any other state is dropped, and clear wins over start.
    state_t                     state;
    logic [XW-1:0]              x0;
    logic [YW-1:0]              y0;
    logic [3:0]                 n;
    logic [3:0]                 row;
    logic [YW-1:0]              clr_row;
    logic [ADDR_W-1:0]          base;
    logic [7:0]                 sprite;
    logic [DISP_W*DISP_H-1:0]   fb;

    logic [YW+4:0]              ry_full;
    logic [YW-1:0]              draw_y;
    logic                       row_ok;
    logic [XW:0]                col;
    logic [DISP_W-1:0]          mask;
    logic [DISP_W-1:0]          old_row;
    logic                       hit;

    // Per-row XOR mask: columns past the right edge either vanish or wrap.
    always_comb begin
        ry_full = (YW+5)'(y0) + (YW+5)'(row);
        draw_y  = ry_full[YW-1:0];
        row_ok  = (CLIP == 0) || (ry_full < H_LIM);
        mask    = '0;
        col     = '0;
        for (int c = 0; c < 8; c++) begin
            col = (XW+1)'(x0) + (XW+1)'(c);
            if (row_ok && ((CLIP == 0) || !col[XW]))
                mask[col[XW-1:0]] = sprite[3'(7 - c)];
        end
        old_row = fb[draw_y*DISP_W +: DISP_W];
        hit     = |(old_row & mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            x0        <= '0;
            y0        <= '0;
            n         <= '0;
            row       <= '0;
            clr_row   <= '0;
            base      <= '0;
            sprite    <= '0;
            fb        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
        end else begin
            done     <= 1'b0;
            mem_read <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        clr_row <= '0;
                        busy    <= 1'b1;
                        state   <= CLR;
                    end else if (start) begin
                        x0        <= XW'(x_in);
                        y0        <= YW'(y_in);
                        n         <= n_in;
                        base      <= i_addr;
                        row       <= '0;
                        collision <= 1'b0;
                        busy      <= 1'b1;
                        if (n_in == 4'd0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= i_addr;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    sprite <= mem_data_in;
                    state  <= DRAW;
                end
                DRAW: begin
                    fb[draw_y*DISP_W +: DISP_W] <= old_row ^ mask;
                    if (hit)
                        collision <= 1'b1;
                    if (row == n - 4'd1) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        row      <= row + 4'd1;
                        mem_read <= 1'b1;
                        mem_addr <= base + ADDR_W'(row) + ADDR_W'(1);
                        state    <= FETCH;
                    end
                end
                CLR: begin
                    fb[clr_row*DISP_W +: DISP_W] <= '0;
                    if (clr_row == LAST_ROW) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        clr_row <= clr_row + 1'b1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign display = fb;

endmodule

// File: tb/tb_chip8_draw_engine.sv
// Bench for chip8_draw_engine: a clipping and a wrapping instance run in lockstep
// against a pixel-level reference model of DXYN / 00E0.
module tb_chip8_draw_engine;

    localparam int W   = 64;
    localparam int H   = 32;
    localparam int AW  = 12;
    localparam int FBW = W * H;

    logic          clk, reset, start, clear;
    logic [7:0]    x_in, y_in;
    logic [3:0]    n_in;
    logic [AW-1:0] i_addr;

    logic [AW-1:0] mem_addr_c, mem_addr_w;
    logic          mem_read_c, mem_read_w;
    logic [7:0]    rd_c, rd_w;
    logic          busy_c, busy_w, done_c, done_w, coll_c, coll_w;
    logic [FBW-1:0] display_c, display_w;

    logic [7:0]     mem [0:4095];
    logic [FBW-1:0] model_fb [2];
    bit             model_coll [2];
    logic [FBW-1:0] exp_q_c [$];
    logic [FBW-1:0] exp_q_w [$];

    int n_cmp = 0;
    int n_err = 0;

    chip8_draw_engine #(.DISP_W(W), .DISP_H(H), .ADDR_W(AW), .CLIP(1)) dut_c (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_addr(i_addr),
        .mem_addr(mem_addr_c), .mem_read(mem_read_c), .mem_data_in(rd_c),
        .busy(busy_c), .done(done_c), .collision(coll_c), .display(display_c)
    );

    chip8_draw_engine #(.DISP_W(W), .DISP_H(H), .ADDR_W(AW), .CLIP(0)) dut_w (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_addr(i_addr),
        .mem_addr(mem_addr_w), .mem_read(mem_read_w), .mem_data_in(rd_w),
        .busy(busy_w), .done(done_w), .collision(coll_w), .display(display_w)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    // program memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_read_c) rd_c <= mem[mem_addr_c];
        if (mem_read_w) rd_w <= mem[mem_addr_w];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_display(input string tag, input logic [FBW-1:0] got, input logic [FBW-1:0] exp);
        for (int r = 0; r < H; r++)
            check($sformatf("%s_row%0d", tag, r), 64'(got[r*W +: W]), 64'(exp[r*W +: W]));
    endtask

    // reference model: k=0 clips at the edges, k=1 wraps
    task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input int n, input int base);
        logic [7:0] b;
        int px, py, idx;
        model_coll[0] = 0;
        model_coll[1] = 0;
        for (int r = 0; r < n; r++) begin
            b = mem[(base + r) % 4096];
            for (int c = 0; c < 8; c++) begin
                if (b[7 - c]) begin
                    px = (int'(x) % W) + c;
                    py = (int'(y) % H) + r;
                    for (int k = 0; k < 2; k++) begin
                        if (k == 0 && (px >= W || py >= H)) continue;
                        idx = (py % H) * W + (px % W);
                        if (model_fb[k][idx]) model_coll[k] = 1;
                        model_fb[k][idx] = ~model_fb[k][idx];
                    end
                end
            end
        end
    endtask

    // driver: one DXYN, checked for latency, fetch addresses, collision and display
    task automatic run_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                            input logic [AW-1:0] base, input bit interfere);
        logic [AW-1:0] exp_addr [$];
        logic [AW-1:0] obs_c [$];
        logic [AW-1:0] obs_w [$];
        int lat_c = 0, lat_w = 0;
        model_draw(x, y, int'(n), int'(base));
        exp_q_c.push_back(model_fb[0]);
        exp_q_w.push_back(model_fb[1]);
        for (int r = 0; r < int'(n); r++) exp_addr.push_back(AW'(int'(base) + r));
        @(negedge clk);
        x_in = x; y_in = y; n_in = n; i_addr = base; start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            clear = 1'b0;
            if (interfere && cyc == 2) begin
                start = 1'b1;
                clear = 1'($urandom_range(0, 1));
                x_in  = 8'($urandom);
                n_in  = 4'($urandom_range(1, 15));
            end
            if (cyc == 1) begin
                check("busy_c_run", 64'(busy_c), 64'd1);
                check("busy_w_run", 64'(busy_w), 64'd1);
            end
            if (mem_read_c) obs_c.push_back(mem_addr_c);
            if (mem_read_w) obs_w.push_back(mem_addr_w);
            if (done_c && lat_c == 0) lat_c = cyc;
            if (done_w && lat_w == 0) lat_w = cyc;
            if (lat_c != 0 && lat_w != 0) break;
        end
        start = 1'b0;
        clear = 1'b0;
        check("draw_latency_c", 64'(lat_c), 64'(3 * int'(n) + 1));
        check("draw_latency_w", 64'(lat_w), 64'(3 * int'(n) + 1));
        check("coll_c", 64'(coll_c), 64'(model_coll[0]));
        check("coll_w", 64'(coll_w), 64'(model_coll[1]));
        check("fetch_count_c", 64'(obs_c.size()), 64'(exp_addr.size()));
        check("fetch_count_w", 64'(obs_w.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < obs_c.size()) check($sformatf("fetch_addr_c%0d", i), 64'(obs_c[i]), 64'(exp_addr[i]));
            if (i < obs_w.size()) check($sformatf("fetch_addr_w%0d", i), 64'(obs_w[i]), 64'(exp_addr[i]));
        end
        check_display("disp_c", display_c, exp_q_c.pop_front());
        check_display("disp_w", display_w, exp_q_w.pop_front());
        @(negedge clk);
        check("idle_busy_c", 64'(busy_c), 64'd0);
        check("idle_busy_w", 64'(busy_w), 64'd0);
        check("idle_done_c", 64'(done_c), 64'd0);
    endtask

    // driver: 00E0, optionally with a simultaneous start that must lose
    task automatic run_clear(input bit with_start);
        int lat_c = 0, lat_w = 0, reads = 0;
        model_fb[0] = '0;
        model_fb[1] = '0;
        exp_q_c.push_back(model_fb[0]);
        exp_q_w.push_back(model_fb[1]);
        @(negedge clk);
        clear = 1'b1;
        start = with_start;
        x_in = 8'($urandom); y_in = 8'($urandom); n_in = 4'd1; i_addr = AW'($urandom);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            clear = 1'b0;
            start = 1'b0;
            if (mem_read_c || mem_read_w) reads++;
            if (done_c && lat_c == 0) lat_c = cyc;
            if (done_w && lat_w == 0) lat_w = cyc;
            if (lat_c != 0 && lat_w != 0) break;
        end
        check("clear_latency_c", 64'(lat_c), 64'(H + 1));
        check("clear_latency_w", 64'(lat_w), 64'(H + 1));
        check("clear_no_fetch", 64'(reads), 64'd0);
        check("clear_coll_c", 64'(coll_c), 64'(model_coll[0]));
        check("clear_coll_w", 64'(coll_w), 64'(model_coll[1]));
        check_display("clr_c", display_c, exp_q_c.pop_front());
        check_display("clr_w", display_w, exp_q_w.pop_front());
        @(negedge clk);
        check("clear_idle_busy", 64'(busy_c), 64'd0);
    endtask

    // driver: async reset landing in the WAIT cycle of a 3-row draw
    task automatic reset_in_wait();
        int pulses = 0;
        @(negedge clk);
        x_in = 8'd5; y_in = 8'd5; n_in = 4'd3; i_addr = 12'h050; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_busy_c", 64'(busy_c), 64'd0);
        check("rst_busy_w", 64'(busy_w), 64'd0);
        check("rst_done_c", 64'(done_c), 64'd0);
        check("rst_mem_read", 64'(mem_read_c), 64'd0);
        check("rst_coll_c", 64'(coll_c), 64'd0);
        check_display("rst_c", display_c, '0);
        check_display("rst_w", display_w, '0);
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (done_c || done_w || busy_c) pulses++;
        end
        check("rst_no_done", 64'(pulses), 64'd0);
        model_fb[0] = '0;
        model_fb[1] = '0;
        model_coll[0] = 0;
        model_coll[1] = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0;
        x_in = '0; y_in = '0; n_in = '0; i_addr = '0;
        model_fb[0] = '0; model_fb[1] = '0;
        model_coll[0] = 0; model_coll[1] = 0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        mem[12'h050] = 8'hF0;
        mem[12'h060] = 8'h0F;
        mem[12'h070] = 8'hFF;
        mem[12'h071] = 8'hFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy_c), 64'd0);
        check("reset_done", 64'(done_c), 64'd0);
        check("reset_coll", 64'(coll_c), 64'd0);
        check("reset_mem_read", 64'(mem_read_c), 64'd0);
        check("reset_mem_addr", 64'(mem_addr_c), 64'd0);
        check_display("reset_c", display_c, '0);
        check_display("reset_w", display_w, '0);

        run_clear(1'b0);

        run_draw(8'd0, 8'd0, 4'd1, 12'h050, 1'b0);
        check("f0_bits", 64'(display_c[7:0]), 64'h0F);
        check("f0_coll", 64'(coll_c), 64'd0);
        run_draw(8'd0, 8'd0, 4'd1, 12'h050, 1'b0);
        check("f0_again_bits", 64'(display_c[7:0]), 64'h00);
        check("f0_again_coll", 64'(coll_c), 64'd1);
        run_draw(8'd0, 8'd0, 4'd1, 12'h060, 1'b0);
        check("0f_bits", 64'(display_c[7:0]), 64'hF0);
        check("0f_coll", 64'(coll_c), 64'd0);

        run_draw(8'd60, 8'd31, 4'd2, 12'h070, 1'b0);
        check("clip_row31", 64'(display_c[31*W +: W]), 64'hF000_0000_0000_0000);
        check("clip_row0", 64'(display_c[0 +: W]), 64'h0000_0000_0000_00F0);
        check("wrap_row31", 64'(display_w[31*W +: W]), 64'hF000_0000_0000_000F);
        check("wrap_row0", 64'(display_w[0 +: W]), 64'hF000_0000_0000_00FF);

        run_draw(8'd68, 8'd10, 4'd1, 12'h050, 1'b0);
        check("x68_row10", 64'(display_c[10*W +: W]), 64'h0000_0000_0000_00F0);

        run_draw(8'd20, 8'd20, 4'd0, 12'h050, 1'b0);
        run_draw(8'd3, 8'd7, 4'd4, 12'h050, 1'b1);
        run_clear(1'b1);
        reset_in_wait();

        for (int t = 0; t < 40; t++) begin
            logic [3:0] n_r;
            n_r = 4'($urandom_range(0, 15));
            if (t % 10 == 9) run_clear(1'($urandom_range(0, 1)));
            run_draw(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), n_r,
                     AW'($urandom_range(0, 4095)), (n_r != 0) && ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/chip8_draw_engine.md
Name: chip8_draw_engine

Overview:
- Parametrised sprite-draw and clear engine for the CHIP-8 framebuffer; it replaces the fixed 64x32 display logic inside the CPU.
- Executes DXYN (draw) and 00E0 (clear) as a multi-cycle operation. It reads sprite bytes from program memory through a read port with 1-cycle latency.
- XORs each byte into a DISP_W x DISP_H bit framebuffer, reports VF collision, and exposes the framebuffer as a flat display bus to chip8_top.

Parameters:
- DISP_W, 64, framebuffer width in pixels; power of two, >= 8.
- DISP_H, 32, framebuffer height in pixels; power of two.
- ADDR_W, 12, memory address width.
- CLIP, 1, edge mode: 1 = discard pixels past the right/bottom edge; 0 = wrap them modulo the dimension.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  1-cycle request to draw a sprite.
- clear  in  1  1-cycle request to clear the screen.
- x_in  in  8  sprite X coordinate (value of VX).
- y_in  in  8  sprite Y coordinate (value of VY).
- n_in  in  4  sprite height in rows.
- i_addr  in  ADDR_W  sprite base address (I register).
- mem_addr  out  ADDR_W  sprite byte read address.
- mem_read  out  1  read strobe.
- mem_data_in  in  8  read data, valid the cycle after mem_read.
- busy  out  1  high while an operation is in progress.
- done  out  1  1-cycle pulse when an operation completes.
- collision  out  1  VF result of the last draw; valid from done onwards.
- display  out  DISP_W*DISP_H  framebuffer; bit index = y*DISP_W + x.

Behaviour:
- Reset (async): framebuffer=0, state=IDLE, busy=0, done=0, collision=0, mem_read=0, mem_addr=0.
- States: IDLE, FETCH, WAIT, DRAW, CLR, FIN.
- IDLE:
  - clear=1 -> CLR (clear has priority over a simultaneous start).
  - else start=1 -> latch x0 = x_in mod DISP_W, y0 = y_in mod DISP_H, n, base; row=0; collision=0; go to FETCH. If n=0, go to FIN instead.
  - start/clear while busy are ignored; they are not queued.
- FETCH: mem_read=1, mem_addr = (base+row) mod 2^ADDR_W -> WAIT.
- WAIT: mem_read=0 -> DRAW (data valid this cycle).
- DRAW (one row per cycle, all 8 bits):
  - Sprite bit 7 maps to column x0, bit 0 to column x0+7.
  - Row index = y0+row.
  - Column or row >= dimension: CLIP=1 skips the pixel; CLIP=0 wraps it modulo the dimension.
  - Pixel ^= bit. Any pixel going 1->0 sets collision (sticky until the next start).
  - row==n-1 -> FIN, else row+1 -> FETCH.
- CLR: zeroes one framebuffer row per cycle, rows 0..DISP_H-1, then FIN; collision unchanged.
- FIN: done=1 for one cycle, busy drops the same cycle -> IDLE.
- busy=1 in every state except IDLE.
- Draw latency: done is asserted 3n+1 cycles after the start edge.
- Clear latency: DISP_H+1 cycles.
- display updates at the end of each DRAW/CLR cycle; it is never glitched across rows.
- Reset mid-operation aborts immediately. No done pulse; the framebuffer is cleared.

Test Plan:
- Reset, then check outputs:
  - display==0, busy=0, collision=0.
  - clear -> done after DISP_H+1 cycles.
- Draw 0xF0 at (0,0), n=1, base 0x050:
  - mem_addr=0x050 observed with mem_read.
  - display bits 0..3 set.
  - done at cycle 4; collision=0.
- Repeat the same draw: pixels 0..3 cleared and collision=1.
- Then draw 0x0F at (0,0): no collision, bits 4..7 set.
- Draw 0xFF at (60,31), n=2:
  - CLIP=1: only bits 31*64+60..63 set; row 32 discarded.
  - CLIP=0 build: also sets columns 0..3 of row 31, and row 0 columns 60..63 and 0..3.
  - Coordinate (x_in=68) behaves as x=4.
- n=0 start -> done at cycle 1 with no mem_read and no display change.
- start asserted mid-draw is ignored.
- clear+start in the same cycle -> clear executes.
- Assert reset during WAIT -> immediate idle, zeroed display, no done pulse.
